mem_lsu: RTL and testbench

- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (mem_wdata, mem_addr, mem_we) and drives the MEM/WB register inputs.
- Non-memory instructions pass straight through.
- Loads and stores run a request/acknowledge transaction on the data-RAM bus and stall the pipeline until completion.
- Handles MIPS byte/halfword/word lanes (big-endian), sign/zero extension, and misalignment.

---
 rtl/mem_lsu_pkg.sv | 27 ++
 rtl/mem_lsu_lane.sv | 99 +++++++++
 rtl/mem_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, bus constants and FSM encoding for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned AluOpW   = 8;
  localparam int unsigned RegW     = 32;
  localparam int unsigned RegAddrW = 5;

  localparam logic [AluOpW-1:0] ExeLbOp  = 8'b1110_0000;
  localparam logic [AluOpW-1:0] ExeLbuOp = 8'b1110_0100;
  localparam logic [AluOpW-1:0] ExeLhOp  = 8'b1110_0001;
  localparam logic [AluOpW-1:0] ExeLhuOp = 8'b1110_0101;
  localparam logic [AluOpW-1:0] ExeLwOp  = 8'b1110_0011;
  localparam logic [AluOpW-1:0] ExeSbOp  = 8'b1110_1000;
  localparam logic [AluOpW-1:0] ExeShOp  = 8'b1110_1001;
  localparam logic [AluOpW-1:0] ExeSwOp  = 8'b1110_1011;

  localparam logic [RegW-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrW-1:0] NopRegAddr   = '0;
  localparam logic                WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuBus  = 2'd1,
    LsuDone = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_lane.sv
// Big-endian lane logic: byte enables, store replication, load extraction and extension.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [AluOpW-1:0] aluop,
  input  logic [1:0]        addr_lo,
  input  logic [RegW-1:0]   store_src,
  input  logic [RegW-1:0]   load_src,
  output logic              is_mem,
  output logic              is_load,
  output logic              misaligned,
  output logic [3:0]        sel,
  output logic [RegW-1:0]   store_data,
  output logic [RegW-1:0]   load_data
);

  logic [7:0]  byte_lane;
  logic [3:0]  byte_sel;
  logic [15:0] half_lane;
  logic [3:0]  half_sel;

  // Address 0 is the most significant byte of the bus word.
  always_comb begin
    byte_lane = '0;
    byte_sel  = '0;
    unique case (addr_lo)
      2'b00: begin byte_lane = load_src[31:24]; byte_sel = 4'b1000; end
      2'b01: begin byte_lane = load_src[23:16]; byte_sel = 4'b0100; end
      2'b10: begin byte_lane = load_src[15:8];  byte_sel = 4'b0010; end
      2'b11: begin byte_lane = load_src[7:0];   byte_sel = 4'b0001; end
    endcase
  end

  assign half_lane = addr_lo[1] ? load_src[15:0] : load_src[31:16];
  assign half_sel  = addr_lo[1] ? 4'b0011 : 4'b1100;

  always_comb begin
    is_mem     = 1'b0;
    is_load    = 1'b0;
    misaligned = 1'b0;
    sel        = '0;
    store_data = '0;
    load_data  = '0;
    case (aluop)
      ExeLbOp: begin
        is_mem    = 1'b1;
        is_load   = 1'b1;
        sel       = byte_sel;
        load_data = {{24{byte_lane[7]}}, byte_lane};
      end
      ExeLbuOp: begin
        is_mem    = 1'b1;
        is_load   = 1'b1;
        sel       = byte_sel;
        load_data = {24'b0, byte_lane};
      end
      ExeLhOp: begin
        is_mem     = 1'b1;
        is_load    = 1'b1;
        misaligned = addr_lo[0];
        sel        = half_sel;
        load_data  = {{16{half_lane[15]}}, half_lane};
      end
      ExeLhuOp: begin
        is_mem     = 1'b1;
        is_load    = 1'b1;
        misaligned = addr_lo[0];
        sel        = half_sel;
        load_data  = {16'b0, half_lane};
      end
      ExeLwOp: begin
        is_mem     = 1'b1;
        is_load    = 1'b1;
        misaligned = |addr_lo;
        sel        = 4'b1111;
        load_data  = load_src;
      end
      ExeSbOp: begin
        is_mem     = 1'b1;
        sel        = byte_sel;
        store_data = {4{store_src[7:0]}};
      end
      ExeShOp: begin
        is_mem     = 1'b1;
        misaligned = addr_lo[0];
        sel        = half_sel;
        store_data = {2{store_src[15:0]}};
      end
      ExeSwOp: begin
        is_mem     = 1'b1;
        misaligned = |addr_lo;
        sel        = 4'b1111;
        store_data = store_src;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline around a req/ack data-RAM transaction.
// Optional MEM_TIMEOUT_EN aborts a bus cycle after TIMEOUT cycles without ack.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RegW-1:0]     wdata_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic                we_i,
  input  logic [AluOpW-1:0]   aluop_i,
  input  logic [RegW-1:0]     mem_addr_i,
  input  logic [RegW-1:0]     reg2_i,
  input  logic [RegW-1:0]     ram_data_i,
  input  logic                ram_ack_i,
  output logic [RegW-1:0]     ram_addr_o,
  output logic [RegW-1:0]     ram_data_o,
  output logic [3:0]          ram_sel_o,
  output logic                ram_we_o,
  output logic                ram_ce_o,
  output logic [RegW-1:0]     wb_wdata_o,
  output logic [RegAddrW-1:0] wb_waddr_o,
  output logic                wb_we_o,
  output logic                stallreq_o,
  output logic                misalign_o,
  output logic                bus_err_o
);

  lsu_state_e state_q, state_d;

  logic [RegW-1:0] ram_addr_q, ram_addr_d;
  logic [RegW-1:0] ram_data_q, ram_data_d;
  logic [3:0]      ram_sel_q, ram_sel_d;
  logic            ram_we_q, ram_we_d;
  logic            ram_ce_q, ram_ce_d;
  logic [RegW-1:0] rdata_q, rdata_d;

  logic            lane_is_mem;
  logic            lane_is_load;
  logic            lane_misaligned;
  logic [3:0]      lane_sel;
  logic [RegW-1:0] lane_store;
  logic [RegW-1:0] lane_load;

  logic            timeout_hit;
  logic            bus_fail;

  mem_lsu_lane u_lane (
    .aluop      (aluop_i),
    .addr_lo    (mem_addr_i[1:0]),
    .store_src  (reg2_i),
    .load_src   (rdata_q),
    .is_mem     (lane_is_mem),
    .is_load    (lane_is_load),
    .misaligned (lane_misaligned),
    .sel        (lane_sel),
    .store_data (lane_store),
    .load_data  (lane_load)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            bus_err_q;

  assign timeout_hit = (state_q == LsuBus) && !ram_ack_i && (cnt_q == CntW'(TIMEOUT - 1));

  // DONE always lasts one cycle, so the error flag doubles as the one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == LsuBus) ? cnt_q + CntW'(1) : '0;
      bus_err_q <= timeout_hit;
    end
  end

  assign bus_fail  = bus_err_q;
  assign bus_err_o = bus_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus_fail       = 1'b0;
  assign bus_err_o      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_sel_d  = ram_sel_q;
    ram_we_d   = ram_we_q;
    ram_ce_d   = ram_ce_q;
    rdata_d    = rdata_q;
    wb_we_o    = WriteDisable;
    wb_waddr_o = waddr_i;
    wb_wdata_o = wdata_i;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;

    unique case (state_q)
      LsuIdle: begin
        if (!lane_is_mem) begin
          wb_we_o = we_i;
        end else if (lane_misaligned) begin
          misalign_o = 1'b1;
        end else begin
          stallreq_o = 1'b1;
          ram_addr_d = {mem_addr_i[RegW-1:2], 2'b00};
          ram_sel_d  = lane_sel;
          ram_data_d = lane_store;
          ram_we_d   = !lane_is_load;
          ram_ce_d   = 1'b1;
          state_d    = LsuBus;
        end
      end
      LsuBus: begin
        stallreq_o = 1'b1;
        if (ram_ack_i) begin
          rdata_d  = ram_data_i;
          ram_ce_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = LsuDone;
        end else if (timeout_hit) begin
          rdata_d  = ZeroWord;
          ram_ce_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = LsuDone;
        end
      end
      LsuDone: begin
        if (lane_is_load && !bus_fail) begin
          wb_we_o    = we_i;
          wb_wdata_o = lane_load;
        end
        state_d = LsuIdle;
      end
      default: state_d = LsuIdle;
    endcase

    if (rst) begin
      wb_we_o    = WriteDisable;
      wb_waddr_o = NopRegAddr;
      wb_wdata_o = ZeroWord;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LsuIdle;
      ram_addr_q <= ZeroWord;
      ram_data_q <= ZeroWord;
      ram_sel_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_ce_q   <= 1'b0;
      rdata_q    <= ZeroWord;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_sel_q  <= ram_sel_d;
      ram_we_q   <= ram_we_d;
      ram_ce_q   <= ram_ce_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_sel_o  = ram_sel_q;
  assign ram_we_o   = ram_we_q;
  assign ram_ce_o   = ram_ce_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; covers the MEM_TIMEOUT_EN build when defined.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata_i, mem_addr_i, reg2_i, ram_data_i;
  logic [4:0]  waddr_i;
  logic        we_i, ram_ack_i;
  logic [7:0]  aluop_i;
  logic [31:0] ram_addr_o, ram_data_o, wb_wdata_o;
  logic [3:0]  ram_sel_o;
  logic        ram_we_o, ram_ce_o, wb_we_o, stallreq_o, misalign_o, bus_err_o;
  logic [4:0]  wb_waddr_o;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wdata_i    (wdata_i),
    .waddr_i    (waddr_i),
    .we_i       (we_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .ram_data_i (ram_data_i),
    .ram_ack_i  (ram_ack_i),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_sel_o  (ram_sel_o),
    .ram_we_o   (ram_we_o),
    .ram_ce_o   (ram_ce_o),
    .wb_wdata_o (wb_wdata_o),
    .wb_waddr_o (wb_waddr_o),
    .wb_we_o    (wb_we_o),
    .stallreq_o (stallreq_o),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs from IDLE until stall drops (or bound expires); snapshots ram_* in the first BUS cycle.
  task automatic mem_txn(input int ack_at, input int bound, output int stalls,
                         output logic [31:0] a, output logic [31:0] d, output logic [3:0] s,
                         output logic w, output logic c);
    stalls = 0;
    a = '0; d = '0; s = '0; w = 1'b0; c = 1'b0;
    for (int cy = 0; cy < bound; cy++) begin
      ram_ack_i = (cy == ack_at);
      #1;
      if (cy == 1) begin
        a = ram_addr_o; d = ram_data_o; s = ram_sel_o; w = ram_we_o; c = ram_ce_o;
      end
      if (!stallreq_o) break;
      stalls++;
      step();
    end
    ram_ack_i = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] ram;
    int          ack_at;
    int          stalls;
    logic [3:0]  sel;
    logic [31:0] sdata;
    logic [31:0] ldata;
    logic        is_store;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          stalls;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    logic        sw, sc;

    vecs[0] = '{ExeLbOp,  32'h101, 32'h0,        32'hAA80CC11, 3, 4, 4'b0100, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[1] = '{ExeShOp,  32'h202, 32'h0000BEEF, 32'h0,        1, 2, 4'b0011, 32'hBEEFBEEF, 32'h0, 1'b1};
    vecs[2] = '{ExeLhuOp, 32'h100, 32'h0,        32'hAA80CC11, 1, 2, 4'b1100, 32'h0, 32'h0000AA80, 1'b0};
    vecs[3] = '{ExeLhOp,  32'h102, 32'h0,        32'h1234F00D, 2, 3, 4'b0011, 32'h0, 32'hFFFFF00D, 1'b0};
    vecs[4] = '{ExeLwOp,  32'h304, 32'h0,        32'hCAFEF00D, 1, 2, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{ExeSbOp,  32'h203, 32'h123456A5, 32'h0,        1, 2, 4'b0001, 32'hA5A5A5A5, 32'h0, 1'b1};
    vecs[6] = '{ExeSwOp,  32'h208, 32'h89ABCDEF, 32'h0,        2, 3, 4'b1111, 32'h89ABCDEF, 32'h0, 1'b1};
    vecs[7] = '{ExeLbuOp, 32'h102, 32'h0,        32'hAA80CC11, 1, 2, 4'b0010, 32'h0, 32'h000000CC, 1'b0};

    rst = 1'b1; wdata_i = 32'h5A5A5A5A; waddr_i = 5'd1; we_i = 1'b1; aluop_i = 8'h00;
    mem_addr_i = '0; reg2_i = '0; ram_data_i = '0; ram_ack_i = 1'b0;
    step();
    step();
    check_eq("rst ram_ce", ram_ce_o, 1'b0);
    check_eq("rst ram_we", ram_we_o, 1'b0);
    check_eq("rst ram_sel", ram_sel_o, 4'h0);
    check_eq("rst ram_addr", ram_addr_o, 32'h0);
    check_eq("rst ram_data", ram_data_o, 32'h0);
    check_eq("rst wb_we", wb_we_o, 1'b0);
    check_eq("rst wb_waddr", wb_waddr_o, 5'd0);
    check_eq("rst wb_wdata", wb_wdata_o, 32'h0);
    check_eq("rst stall", stallreq_o, 1'b0);
    check_eq("rst misalign", misalign_o, 1'b0);
    check_eq("rst bus_err", bus_err_o, 1'b0);
    rst = 1'b0;

    // Pass-through; a stray ack in IDLE must be ignored.
    aluop_i = 8'h25; wdata_i = 32'h12345678; waddr_i = 5'd3; we_i = 1'b1; ram_ack_i = 1'b1;
    #1;
    check_eq("pass wb_wdata", wb_wdata_o, 32'h12345678);
    check_eq("pass wb_waddr", wb_waddr_o, 5'd3);
    check_eq("pass wb_we", wb_we_o, 1'b1);
    check_eq("pass stall", stallreq_o, 1'b0);
    step();
    ram_ack_i = 1'b0;
    #1;
    check_eq("idle ack ignored ce", ram_ce_o, 1'b0);
    check_eq("idle ack ignored stall", stallreq_o, 1'b0);

    foreach (vecs[i]) begin
      aluop_i = vecs[i].op; mem_addr_i = vecs[i].addr; wdata_i = vecs[i].addr;
      reg2_i = vecs[i].reg2; ram_data_i = vecs[i].ram; waddr_i = 5'd9; we_i = 1'b1;
      mem_txn(vecs[i].ack_at, 40, stalls, sa, sd, ss, sw, sc);
      check_eq($sformatf("v%0d stalls", i), stalls, vecs[i].stalls);
      check_eq($sformatf("v%0d ram_ce", i), sc, 1'b1);
      check_eq($sformatf("v%0d ram_sel", i), ss, vecs[i].sel);
      check_eq($sformatf("v%0d ram_addr", i), sa, vecs[i].addr & 32'hFFFFFFFC);
      check_eq($sformatf("v%0d ram_we", i), sw, vecs[i].is_store);
      check_eq($sformatf("v%0d done ce", i), ram_ce_o, 1'b0);
      check_eq($sformatf("v%0d done stall", i), stallreq_o, 1'b0);
      check_eq($sformatf("v%0d wb_we", i), wb_we_o, !vecs[i].is_store);
      if (vecs[i].is_store) begin
        check_eq($sformatf("v%0d ram_data", i), sd, vecs[i].sdata);
      end else begin
        check_eq($sformatf("v%0d wb_wdata", i), wb_wdata_o, vecs[i].ldata);
        check_eq($sformatf("v%0d wb_waddr", i), wb_waddr_o, 5'd9);
      end
      step();
      aluop_i = 8'h00; we_i = 1'b0;
      #1;
    end

    // Misaligned accesses: single-cycle pulse, no bus activity.
    aluop_i = ExeLwOp; mem_addr_i = 32'h303; we_i = 1'b1;
    #1;
    check_eq("mis lw pulse", misalign_o, 1'b1);
    check_eq("mis lw stall", stallreq_o, 1'b0);
    check_eq("mis lw wb_we", wb_we_o, 1'b0);
    step();
    check_eq("mis lw ce", ram_ce_o, 1'b0);
    aluop_i = ExeShOp; mem_addr_i = 32'h201;
    #1;
    check_eq("mis sh pulse", misalign_o, 1'b1);
    aluop_i = 8'h00;
    #1;
    check_eq("mis cleared", misalign_o, 1'b0);
    step();
    check_eq("mis sh ce", ram_ce_o, 1'b0);

    // Reset in BUS with a simultaneous ack.
    aluop_i = ExeLwOp; mem_addr_i = 32'h300; we_i = 1'b1; waddr_i = 5'd4;
    step();
    check_eq("rbus ce", ram_ce_o, 1'b1);
    rst = 1'b1; ram_ack_i = 1'b1; ram_data_i = 32'hDEADBEEF;
    #1;
    check_eq("rbus during wb_we", wb_we_o, 1'b0);
    step();
    rst = 1'b0; ram_ack_i = 1'b0;
    #1;
    check_eq("rbus after ce", ram_ce_o, 1'b0);
    check_eq("rbus after wb_we", wb_we_o, 1'b0);
    check_eq("rbus restarts from idle", stallreq_o, 1'b1);
    aluop_i = 8'h00;
    step();
    check_eq("rbus idle ce", ram_ce_o, 1'b0);

    // No ack at all.
    aluop_i = ExeLwOp; mem_addr_i = 32'h400; we_i = 1'b1;
`ifdef MEM_TIMEOUT_EN
    mem_txn(-1, 40, stalls, sa, sd, ss, sw, sc);
    check_eq("tmo stalls", stalls, 17);
    check_eq("tmo bus_err", bus_err_o, 1'b1);
    check_eq("tmo wb_we", wb_we_o, 1'b0);
    check_eq("tmo ce", ram_ce_o, 1'b0);
    aluop_i = 8'h00;
    step();
    check_eq("tmo pulse end", bus_err_o, 1'b0);
    check_eq("tmo stall free", stallreq_o, 1'b0);
`else
    mem_txn(-1, 30, stalls, sa, sd, ss, sw, sc);
    check_eq("hang stalls", stalls, 30);
    check_eq("hang still stalled", stallreq_o, 1'b1);
    check_eq("hang ce", ram_ce_o, 1'b1);
    check_eq("hang bus_err", bus_err_o, 1'b0);
    rst = 1'b1; aluop_i = 8'h00;
    step();
    rst = 1'b0;
    #1;
    check_eq("hang recover ce", ram_ce_o, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
